// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - control/feedback bundle between counter_ctrl and the counter datapath
`timescale 1ns/1ps
interface counter_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] cnt_q;
  logic         cnt_en;
  logic         cnt_ld;
  logic         cnt_up;
  logic [W-1:0] cnt_d;

  modport master (input cnt_q, output cnt_en, cnt_ld, cnt_up, cnt_d);
  modport slave  (output cnt_q, input cnt_en, cnt_ld, cnt_up, cnt_d);
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run/pause/load FSM and tick prescaler for an up/down counter
// Define COUNTER_CTRL_DEBOUNCE_EN to insert a DB_CYCLES key debouncer after the synchronizers.
`timescale 1ns/1ps
module counter_ctrl #(
  parameter int W         = 8,
  parameter int TICK_DIV  = 5000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic         CLOCK_50,
  input  logic         Resetn,
  input  logic         go_n,
  input  logic         load_n,
  input  logic         dir,
  input  logic         oneshot,
  input  logic [W-1:0] load_val,
  counter_ctrl_if.master cnt,
  output logic [1:0]   state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DB_CYCLES < 1) begin : g_param_chk
    $error("counter_ctrl: TICK_DIV must be >= 2 and DB_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOAD  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_ld_q, cnt_ld_d;
  logic [W-1:0]  cnt_d_q, cnt_d_d;

  // Bit 0 = go_n, bit 1 = load_n, bit 2 = dir; all idle high so reset never looks like a press.
  logic [2:0] meta_q, sync_q;
  logic [1:0] key_lvl, prev_q;
  logic       go_p, ld_p, tick, term;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
      prev_q <= 2'b11;
    end else begin
      meta_q <= {dir, load_n, go_n};
      sync_q <= meta_q;
      prev_q <= key_lvl;
    end
  end

`ifdef COUNTER_CTRL_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  logic [1:0]     db_q;
  logic [DBW-1:0] db_cnt_q [2];

  // A key's accepted level only follows the synchronizer after DB_CYCLES identical samples.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      db_q        <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sync_q[k] == db_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DBW'(DB_CYCLES - 1)) begin
          db_q[k]     <= sync_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DBW'(1);
        end
      end
    end
  end
  assign key_lvl = db_q;
`else
  assign key_lvl = sync_q[1:0];
`endif

  assign go_p = prev_q[0] & ~key_lvl[0];
  assign ld_p = prev_q[1] & ~key_lvl[1];
  assign tick = (state_q == RUN) && (presc_q == PMAX);
  assign term = sync_q[2] ? (&cnt.cnt_q) : ~(|cnt.cnt_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_en_d = 1'b0;
    cnt_ld_d = 1'b0;
    cnt_d_d  = cnt_d_q;
    unique case (state_q)
      IDLE: begin
        if (ld_p) begin
          state_d = LOAD;
        end else if (go_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A press on the tick cycle wins; the count pulse is dropped.
        if (ld_p) begin
          state_d = LOAD;
        end else if (go_p) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (oneshot && term) state_d = IDLE;
          else                 cnt_en_d = 1'b1;
        end
      end
      PAUSE: begin
        if (ld_p)      state_d = LOAD;
        else if (go_p) state_d = RUN;
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD && state_q != LOAD) begin
      presc_d = '0;
      cnt_d_d = load_val;
    end
    cnt_ld_d = (state_d == LOAD);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_en_q <= 1'b0;
      cnt_ld_q <= 1'b0;
      cnt_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_en_q <= cnt_en_d;
      cnt_ld_q <= cnt_ld_d;
      cnt_d_q  <= cnt_d_d;
    end
  end

  assign cnt.cnt_en = cnt_en_q;
  assign cnt.cnt_ld = cnt_ld_q;
  assign cnt.cnt_d  = cnt_d_q;
  assign cnt.cnt_up = sync_q[2];
  assign state      = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - vector table plus scoreboard checks for counter_ctrl (TICK_DIV=4, W=8)
`timescale 1ns/1ps
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       go_n, load_n, dir, oneshot;
  logic [7:0] load_val;
  logic [1:0] state;

  counter_ctrl_if #(.W(8)) cif ();

  counter_ctrl #(.W(8), .TICK_DIV(4), .DB_CYCLES(3)) dut (
    .CLOCK_50 (clk),
    .Resetn   (Resetn),
    .go_n     (go_n),
    .load_n   (load_n),
    .dir      (dir),
    .oneshot  (oneshot),
    .load_val (load_val),
    .cnt      (cif.master),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       g, l, dr, os;
    logic [7:0] q, lv;
    logic [1:0] st;
    logic       en, ld;
    logic [7:0] d;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic v(input logic g, l, dr, os, input logic [7:0] q, lv,
                   input logic [1:0] st, input logic en, ld, input logic [7:0] d);
    vecs.push_back('{g, l, dr, os, q, lv, st, en, ld, d});
  endtask

  function automatic logic [11:0] outs();
    return {state, cif.cnt_en, cif.cnt_ld, cif.cnt_d};
  endfunction

  initial begin
    exp_t e;
    int   changes;
    logic [1:0] prev_st;
    logic found, bad;

    Resetn = 1'b0; go_n = 1'b1; load_n = 1'b1; dir = 1'b1; oneshot = 1'b0;
    load_val = 8'h5A; cif.cnt_q = 8'h10;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", {20'd0, outs()}, 32'd0);
    @(negedge clk) Resetn = 1'b1;

    // go press, first tick after a full period, steady ticks
    v(1,1,1,0,8'h10,8'h5A, 2'd0,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd0,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd0,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd0,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,1,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,1,0,8'h00);
    // pause with prescaler at 2, resume: tick one cycle after resume
    v(0,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd2,0,0,8'h00);
    v(0,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,1,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,1,1,0,8'h10,8'h5A, 2'd1,1,0,8'h00);
    // load from RUN; cnt_d keeps the value captured on entry
    v(1,0,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,0,1,0,8'h10,8'h5A, 2'd1,0,0,8'h00);
    v(1,0,1,0,8'h10,8'h5A, 2'd3,0,1,8'h5A);
    v(1,1,1,0,8'h10,8'h33, 2'd0,0,0,8'h5A);
    v(1,1,1,0,8'h10,8'h33, 2'd0,0,0,8'h5A);
    // simultaneous go + load: load wins
    v(0,0,1,0,8'h10,8'h33, 2'd0,0,0,8'h5A);
    v(0,0,1,0,8'h10,8'h33, 2'd0,0,0,8'h5A);
    v(0,0,1,0,8'h10,8'h33, 2'd3,0,1,8'h33);
    v(1,1,1,0,8'h10,8'h33, 2'd0,0,0,8'h33);
    v(1,1,1,0,8'h10,8'h33, 2'd0,0,0,8'h33);
    v(1,1,1,0,8'h10,8'h33, 2'd0,0,0,8'h33);
    // oneshot at terminal count: back to IDLE with no pulse
    v(0,1,1,1,8'hFF,8'h33, 2'd0,0,0,8'h33);
    v(0,1,1,1,8'hFF,8'h33, 2'd0,0,0,8'h33);
    v(0,1,1,1,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,1,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,1,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,1,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,1,8'hFF,8'h33, 2'd0,0,0,8'h33);
    // wrap mode at the same value still counts
    v(0,1,1,0,8'hFF,8'h33, 2'd0,0,0,8'h33);
    v(0,1,1,0,8'hFF,8'h33, 2'd0,0,0,8'h33);
    v(0,1,1,0,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,0,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,0,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,0,8'hFF,8'h33, 2'd1,0,0,8'h33);
    v(1,1,1,0,8'hFF,8'h33, 2'd1,1,0,8'h33);

    foreach (vecs[i]) begin
      @(negedge clk);
      go_n = vecs[i].g; load_n = vecs[i].l; dir = vecs[i].dr; oneshot = vecs[i].os;
      cif.cnt_q = vecs[i].q; load_val = vecs[i].lv;
      sb.push_back('{i, {vecs[i].st, vecs[i].en, vecs[i].ld, vecs[i].d}});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d {state,en,ld,d}", e.idx), {20'd0, outs()}, {20'd0, e.val});
    end

    // go held low for 100 cycles: exactly one transition (RUN -> PAUSE)
    @(negedge clk) go_n = 1'b0;
    changes = 0;
    prev_st = state;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (state !== prev_st) changes++;
      prev_st = state;
    end
    chk("held_go_transitions", changes, 1);
    chk("held_go_state", {30'd0, state}, 32'd2);

    @(negedge clk) go_n = 1'b1;
    repeat (3) @(negedge clk);
    go_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("resume_state", {30'd0, state}, 32'd1);
    @(negedge clk) go_n = 1'b1;

    // reset while cnt_en is high
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      if (cif.cnt_en === 1'b1) found = 1'b1;
    end
    chk("en_seen_before_reset", {31'd0, found}, 32'd1);
    #2 Resetn = 1'b0;
    #1 chk("async_reset_run", {20'd0, outs()}, 32'd0);
    @(negedge clk) Resetn = 1'b1;

    // reset while in LOAD
    load_val = 8'hC3;
    @(negedge clk) load_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("load_before_reset", {20'd0, outs()}, {20'd0, 2'd3, 1'b0, 1'b1, 8'hC3});
    #2 Resetn = 1'b0;
    #1 chk("async_reset_load", {20'd0, outs()}, 32'd0);
    @(negedge clk) load_n = 1'b1;
    @(negedge clk) Resetn = 1'b1;

    bad = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (outs() !== 12'd0) bad = 1'b1;
    end
    chk("quiet_after_reset", {31'd0, bad}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
